// File: rtl/led_pkg.sv
// Shared definitions for the LED trail PWM output stage: default channel
// count and PWM width, the full-scale level constant, and the saturating
// subtract used by the fade path.
package led_pkg;

  localparam int N_LED_DEF    = 8;
  localparam int PWM_BITS_DEF = 8;

  // Full-scale level at the default PWM width (2^PWM_BITS-1).
  localparam logic [PWM_BITS_DEF-1:0] LEVEL_MAX = '1;

  // Arithmetic width of the saturating subtract; levels up to 16 bits fit.
  localparam int SAT_W = 16;

  // a - b, clamped at zero instead of wrapping to large values.
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: holds the brightness level, loads full scale while the
// pattern bit is lit, fades it down on fade ticks (LED_TRAIL_FADE_EN), caps
// it by the global DIM value and compares against the shared PWM counter.
// Without LED_TRAIL_FADE_EN the level simply follows the pattern bit.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF
`ifdef LED_TRAIL_FADE_EN
  ,
  parameter int FADE_STEP = 16
`endif
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                pat,
`ifdef LED_TRAIL_FADE_EN
  input  logic                tick,
`endif
  input  logic [PWM_BITS-1:0] dim,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic signed [PWM_BITS:0]   lvl_s;
  logic [PWM_BITS-1:0]        lvl_p0;
  logic [PWM_BITS-1:0]        eff;
  logic                       led_p1;

`ifdef LED_TRAIL_FADE_EN
  logic [PWM_BITS-1:0]        lvl_dec;

  // Linear fade: one FADE_STEP per tick, parked at zero once exhausted.
  assign lvl_dec = PWM_BITS'(sat_sub(SAT_W'(lvl_p0), SAT_W'(FADE_STEP)));
`endif

  // Stage p0: brightness level; a lit pattern bit always wins over a fade tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lvl_p0 <= '0;
    end else if (pat) begin
      lvl_p0 <= LVL_MAX;
`ifdef LED_TRAIL_FADE_EN
    end else if (tick) begin
      lvl_p0 <= lvl_dec;
`else
    end else begin
      lvl_p0 <= '0;
`endif
    end
  end

  // Level viewed as a signed quantity with a zero sign bit, so the cap
  // comparison below is an explicit non-negative compare.
  assign lvl_s = $signed({1'b0, lvl_p0});

  // Effective brightness: the level, limited by the global cap.
  assign eff = (lvl_s < $signed({1'b0, dim})) ? lvl_p0 : dim;

  // Stage p1: registered PWM compare; eff == 0 keeps the LED dark all frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      led_p1 <= 1'b0;
    end else begin
      led_p1 <= (eff > cnt);
    end
  end

  assign led = led_p1;

endmodule

// File: rtl/led_trail_pwm.sv
// LED trail PWM output stage. Drives N_LED LEDs from the chaser pattern with
// a shared PWM counter; channels that drop out of the pattern fade linearly
// to produce a comet trail. FRAME pulses during the cycle in which the PWM
// counter sits at zero.
//
// Build option: define LED_TRAIL_FADE_EN to include the fade prescaler and
// the per-channel decrement path. When it is not defined the block is a plain
// dimmer (level follows the pattern bit) and FADE_DIV / FADE_STEP are inert.
module led_trail_pwm
  import led_pkg::*;
#(
  parameter int N_LED     = N_LED_DEF,
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int FADE_DIV  = 1024,
  parameter int FADE_STEP = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_LED-1:0]    PAT,
  input  logic [PWM_BITS-1:0] DIM,
  output logic [N_LED-1:0]    LED,
  output logic                FRAME
);

  // Last counter value of a PWM period; equals the package constant at the
  // default width.
  localparam logic [PWM_BITS-1:0] CNT_LAST =
    (PWM_BITS == PWM_BITS_DEF) ? PWM_BITS'(LEVEL_MAX) : '1;

  logic [PWM_BITS-1:0] cnt;

  // Free-running PWM counter shared by every channel.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Period marker, registered from the counter's last value so it is high
  // while the counter reads zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FRAME <= 1'b0;
    end else begin
      FRAME <= (cnt == CNT_LAST);
    end
  end

`ifdef LED_TRAIL_FADE_EN
  localparam int              PRE_W    = $clog2(FADE_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (pre == PRE_LAST);

  // Fade prescaler: one tick every FADE_DIV clocks, first at edge FADE_DIV.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end
`else
  // Fade settings have no effect in this build; keep them referenced.
  logic [63:0] fade_cfg_unused;
  assign fade_cfg_unused = {32'(FADE_DIV), 32'(FADE_STEP)};
`endif

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS)
`ifdef LED_TRAIL_FADE_EN
      ,
      .FADE_STEP (FADE_STEP)
`endif
    ) u_ch (
      .CLK  (CLK),
      .RST  (RST),
      .pat  (PAT[g]),
`ifdef LED_TRAIL_FADE_EN
      .tick (tick),
`endif
      .dim  (DIM),
      .cnt  (cnt),
      .led  (LED[g])
    );
  end

endmodule
